dispatch_ctrl: RTL and testbench

Dual-issue dispatch controller between the pair of instruction decoders and the two execute pipes. It buffers up to two decoded instructions per cycle in a small in-order queue and issues zero, one or two per cycle to the back end. Dual issue is blocked on intra-pair register hazards and on instructions that must issue alone (privileged/CSR, or carrying an exception). It also handles back-pressure to decode and pipeline flush.

---
 rtl/dispatch_pkg.sv | 34 +++
 rtl/dispatch_queue.sv | 61 ++++++
 rtl/dispatch_ctrl.sv | 92 +++++++++
 tb/tb_dispatch_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared dispatch types: decoded-instruction metadata, queue depth and the
// bit positions a decoder ORs together to form its per-slot solo flag.
package dispatch_pkg;
  localparam int DISPATCH_DEPTH = 4;
  localparam int NUM_LANES      = 2;
  localparam int SOLO_PRIV_BIT  = 0;
  localparam int SOLO_CSR_BIT   = 1;
  localparam int SOLO_EXC_BIT   = 2;
  localparam int SOLO_W         = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic        r1_en;
    logic [4:0]  r1;
    logic        r2_en;
    logic [4:0]  r2;
    logic        solo;
  } dinst_t;

  function automatic logic solo_of(input logic [SOLO_W-1:0] cond);
    return |cond;
  endfunction

  // RAW or WAW between an older entry e0 and the younger e1; r0 never conflicts.
  function automatic logic pair_hazard(input dinst_t e0, input dinst_t e1);
    logic w0;
    w0 = e0.we && (e0.waddr != 5'd0);
    return w0 && ((e1.r1_en && (e1.r1 == e0.waddr)) ||
                  (e1.r2_en && (e1.r2 == e0.waddr)) ||
                  (e1.we    && (e1.waddr == e0.waddr)));
  endfunction
endpackage

// File: rtl/dispatch_queue.sv
// 2-write / 2-read circular instruction buffer with head/tail/count and flush.
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH     = DISPATCH_DEPTH,
  parameter int PAYLOAD_W = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [1:0]                   wr_en,
  input  dinst_t [1:0]                 wr_inst,
  input  logic [1:0][PAYLOAD_W-1:0]    wr_payload,
  input  logic [1:0]                   rd_adv,
  output dinst_t [1:0]                 rd_inst,
  output logic [1:0][PAYLOAD_W-1:0]    rd_payload,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dinst_t               mem  [DEPTH];
  logic [PAYLOAD_W-1:0] pmem [DEPTH];
  logic [AW-1:0]        head, tail, head_p1, tail_p1;
  logic [1:0]           n_wr;
  logic                 first;

  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);
  assign n_wr    = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
  // A lone slot-1 instruction is compacted down to tail.
  assign first   = ~wr_en[0];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(rd_adv);
      tail  <= tail + AW'(n_wr);
      count <= count + CW'(n_wr) - CW'(rd_adv);
    end
  end

  always_ff @(posedge clk) begin
    if (|wr_en) begin
      mem[tail]  <= wr_inst[first];
      pmem[tail] <= wr_payload[first];
    end
    if (&wr_en) begin
      mem[tail_p1]  <= wr_inst[1];
      pmem[tail_p1] <= wr_payload[1];
    end
  end

  assign rd_inst[0]    = mem[head];
  assign rd_inst[1]    = mem[head_p1];
  assign rd_payload[0] = pmem[head];
  assign rd_payload[1] = pmem[head_p1];
endmodule

// File: rtl/dispatch_ctrl.sv
// Dual-issue dispatch: buffers decoder pairs and issues 0/1/2 per cycle,
// splitting pairs on register hazards or solo instructions.
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int DEPTH     = DISPATCH_DEPTH,
  parameter int PAYLOAD_W = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [1:0]                dec_valid,
  input  logic [1:0][31:0]          dec_pc,
  input  logic [1:0]                dec_reg_write_en,
  input  logic [1:0][4:0]           dec_reg_write_addr,
  input  logic [1:0]                dec_reg1_read_en,
  input  logic [1:0][4:0]           dec_reg1_read_addr,
  input  logic [1:0]                dec_reg2_read_en,
  input  logic [1:0][4:0]           dec_reg2_read_addr,
  input  logic [1:0]                dec_solo,
  input  logic [1:0][PAYLOAD_W-1:0] dec_payload,
  output logic                      dec_ready,
  output logic [1:0]                issue_valid,
  output logic [1:0][31:0]          issue_pc,
  output logic [1:0]                issue_reg_write_en,
  output logic [1:0][4:0]           issue_reg_write_addr,
  output logic [1:0]                issue_reg1_read_en,
  output logic [1:0][4:0]           issue_reg1_read_addr,
  output logic [1:0]                issue_reg2_read_en,
  output logic [1:0][4:0]           issue_reg2_read_addr,
  output logic [1:0][PAYLOAD_W-1:0] issue_payload,
  input  logic                      issue_ready,
  output logic [31:0]               dual_issue_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  dinst_t [1:0]  wr_inst, rd_inst;
  logic [CW-1:0] count;
  logic [CW:0]   room;
  logic [1:0]    n_deq, wr_en;
  logic          pair_ok;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wr_inst[i] = '{pc:    dec_pc[i],
                          we:    dec_reg_write_en[i],
                          waddr: dec_reg_write_addr[i],
                          r1_en: dec_reg1_read_en[i],
                          r1:    dec_reg1_read_addr[i],
                          r2_en: dec_reg2_read_en[i],
                          r2:    dec_reg2_read_addr[i],
                          solo:  dec_solo[i]};
    assign issue_pc[i]             = rd_inst[i].pc;
    assign issue_reg_write_en[i]   = rd_inst[i].we;
    assign issue_reg_write_addr[i] = rd_inst[i].waddr;
    assign issue_reg1_read_en[i]   = rd_inst[i].r1_en;
    assign issue_reg1_read_addr[i] = rd_inst[i].r1;
    assign issue_reg2_read_en[i]   = rd_inst[i].r2_en;
    assign issue_reg2_read_addr[i] = rd_inst[i].r2;
  end

  assign pair_ok = (count >= CW'(2)) && !rd_inst[0].solo && !rd_inst[1].solo &&
                   !pair_hazard(rd_inst[0], rd_inst[1]);

  // Flush kills issue in its own cycle so nothing is counted as accepted.
  assign issue_valid[0] = !flush && (count != '0);
  assign issue_valid[1] = !flush && pair_ok;

  assign n_deq = issue_ready ? {issue_valid[1], issue_valid[0] & ~issue_valid[1]} : 2'd0;

  // Free slots after this cycle's dequeue; decode needs room for a full pair.
  assign room      = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(n_deq);
  assign dec_ready = (room >= (CW+1)'(2));
  assign wr_en     = (dec_ready && !flush) ? dec_valid : 2'b00;

  dispatch_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_inst    (wr_inst),
    .wr_payload (dec_payload),
    .rd_adv     (n_deq),
    .rd_inst    (rd_inst),
    .rd_payload (issue_payload),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (rst)                             dual_issue_cnt <= '0;
    else if (issue_ready && &issue_valid) dual_issue_cnt <= dual_issue_cnt + 32'd1;
  end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: pairing, hazards, solo, full/wrap, flush, reset.
module tb_dispatch_ctrl;
  logic              clk = 1'b0;
  logic              rst, flush, issue_ready, dec_ready;
  logic [1:0]        dec_valid, dec_reg_write_en, dec_reg1_read_en, dec_reg2_read_en, dec_solo;
  logic [1:0][31:0]  dec_pc;
  logic [1:0][4:0]   dec_reg_write_addr, dec_reg1_read_addr, dec_reg2_read_addr;
  logic [1:0][127:0] dec_payload;
  logic [1:0]        issue_valid, issue_reg_write_en, issue_reg1_read_en, issue_reg2_read_en;
  logic [1:0][31:0]  issue_pc;
  logic [1:0][4:0]   issue_reg_write_addr, issue_reg1_read_addr, issue_reg2_read_addr;
  logic [1:0][127:0] issue_payload;
  logic [31:0]       dual_issue_cnt;
  logic [31:0]       exp_cnt;
  int checks = 0;
  int bad    = 0;

  dispatch_ctrl #(.DEPTH(4), .PAYLOAD_W(128)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_reg_write_en(dec_reg_write_en), .dec_reg_write_addr(dec_reg_write_addr),
    .dec_reg1_read_en(dec_reg1_read_en), .dec_reg1_read_addr(dec_reg1_read_addr),
    .dec_reg2_read_en(dec_reg2_read_en), .dec_reg2_read_addr(dec_reg2_read_addr),
    .dec_solo(dec_solo), .dec_payload(dec_payload), .dec_ready(dec_ready),
    .issue_valid(issue_valid), .issue_pc(issue_pc),
    .issue_reg_write_en(issue_reg_write_en), .issue_reg_write_addr(issue_reg_write_addr),
    .issue_reg1_read_en(issue_reg1_read_en), .issue_reg1_read_addr(issue_reg1_read_addr),
    .issue_reg2_read_en(issue_reg2_read_en), .issue_reg2_read_addr(issue_reg2_read_addr),
    .issue_payload(issue_payload), .issue_ready(issue_ready),
    .dual_issue_cnt(dual_issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_slot(input int l, input logic [31:0] pc, input logic we, input logic [4:0] wa,
                          input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
                          input logic solo);
    dec_pc[l] = pc; dec_reg_write_en[l] = we; dec_reg_write_addr[l] = wa;
    dec_reg1_read_en[l] = r1e; dec_reg1_read_addr[l] = r1;
    dec_reg2_read_en[l] = r2e; dec_reg2_read_addr[l] = r2;
    dec_solo[l] = solo; dec_payload[l] = {pc, ~pc, pc, ~pc};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; dec_valid = 2'b00; issue_ready = 1'b1;
    set_slot(0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(); step();
    rst = 1'b0; #1;
    exp_cnt = 32'd0;
    checks++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", issue_valid); end
    checks++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", dec_ready); end
    checks++; if (dual_issue_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", dual_issue_cnt); end
  endtask

  task automatic test_dual();
    set_slot(0, 32'h1c000000, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0);
    set_slot(1, 32'h1c000004, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0);
    dec_valid = 2'b11; #1;
    checks++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL dual_ready got=%b exp=1", dec_ready); end
    step(); dec_valid = 2'b00; #1;
    checks++; if (issue_valid !== 2'b11) begin bad++; $display("FAIL dual_valid got=%b exp=11", issue_valid); end
    checks++; if (issue_pc[0] !== 32'h1c000000 || issue_pc[1] !== 32'h1c000004) begin bad++; $display("FAIL dual_pc got=%h/%h exp=1c000000/1c000004", issue_pc[0], issue_pc[1]); end
    checks++; if (issue_reg_write_addr[1] !== 5'd4 || issue_reg2_read_addr[0] !== 5'd3) begin bad++; $display("FAIL dual_regs got=%0d/%0d exp=4/3", issue_reg_write_addr[1], issue_reg2_read_addr[0]); end
    checks++; if (issue_payload[1] !== 128'h1c000004_e3fffffb_1c000004_e3fffffb) begin bad++; $display("FAIL dual_payload got=%h", issue_payload[1]); end
    step(); exp_cnt = 32'd1;
    checks++; if (dual_issue_cnt !== exp_cnt) begin bad++; $display("FAIL dual_cnt got=%0d exp=%0d", dual_issue_cnt, exp_cnt); end
    checks++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL dual_empty got=%b exp=00", issue_valid); end
  endtask

  task automatic test_raw();
    set_slot(0, 32'h1c000008, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0);
    set_slot(1, 32'h1c00000c, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b0);
    dec_valid = 2'b11; step(); dec_valid = 2'b00; #1;
    checks++; if (issue_valid !== 2'b01 || issue_pc[0] !== 32'h1c000008) begin bad++; $display("FAIL raw_first got=%b/%h exp=01/1c000008", issue_valid, issue_pc[0]); end
    step();
    checks++; if (issue_valid !== 2'b01 || issue_pc[0] !== 32'h1c00000c) begin bad++; $display("FAIL raw_second got=%b/%h exp=01/1c00000c", issue_valid, issue_pc[0]); end
    step();
    checks++; if (issue_valid !== 2'b00 || dual_issue_cnt !== exp_cnt) begin bad++; $display("FAIL raw_cnt got=%b/%0d exp=00/%0d", issue_valid, dual_issue_cnt, exp_cnt); end
  endtask

  task automatic test_r0();
    set_slot(0, 32'h1c000010, 1'b1, 5'd0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h1c000014, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    dec_valid = 2'b11; step(); dec_valid = 2'b00; #1;
    checks++; if (issue_valid !== 2'b11) begin bad++; $display("FAIL r0_valid got=%b exp=11", issue_valid); end
    step(); exp_cnt = exp_cnt + 32'd1;
    checks++; if (dual_issue_cnt !== exp_cnt) begin bad++; $display("FAIL r0_cnt got=%0d exp=%0d", dual_issue_cnt, exp_cnt); end
  endtask

  task automatic test_solo();
    set_slot(0, 32'h1c000020, 1'b1, 5'd8, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h1c000024, 1'b1, 5'd10, 1'b1, 5'd11, 1'b0, 5'd0, 1'b1);
    dec_valid = 2'b11; step(); dec_valid = 2'b00; #1;
    checks++; if (issue_valid !== 2'b01 || issue_pc[0] !== 32'h1c000020) begin bad++; $display("FAIL solo_addi got=%b/%h exp=01/1c000020", issue_valid, issue_pc[0]); end
    step();
    checks++; if (issue_valid !== 2'b01 || issue_pc[0] !== 32'h1c000024) begin bad++; $display("FAIL solo_csr got=%b/%h exp=01/1c000024", issue_valid, issue_pc[0]); end
    set_slot(0, 32'h1c000028, 1'b1, 5'd12, 1'b1, 5'd13, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h1c00002c, 1'b1, 5'd14, 1'b1, 5'd15, 1'b0, 5'd0, 1'b0);
    dec_valid = 2'b11; #1;
    checks++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL solo_ready got=%b exp=1", dec_ready); end
    step(); dec_valid = 2'b00; #1;
    checks++; if (issue_valid !== 2'b11 || issue_pc[1] !== 32'h1c00002c) begin bad++; $display("FAIL solo_resume got=%b/%h exp=11/1c00002c", issue_valid, issue_pc[1]); end
    step(); exp_cnt = exp_cnt + 32'd1;
    checks++; if (dual_issue_cnt !== exp_cnt) begin bad++; $display("FAIL solo_cnt got=%0d exp=%0d", dual_issue_cnt, exp_cnt); end
  endtask

  task automatic test_waw_compact();
    set_slot(0, 32'h1c000030, 1'b1, 5'd7, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h1c000034, 1'b1, 5'd7, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0);
    dec_valid = 2'b11; step(); dec_valid = 2'b00; #1;
    checks++; if (issue_valid !== 2'b01) begin bad++; $display("FAIL waw_split got=%b exp=01", issue_valid); end
    step(); step();
    set_slot(1, 32'h1c000040, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    dec_valid = 2'b10; step(); dec_valid = 2'b00; #1;
    checks++; if (issue_valid !== 2'b01 || issue_pc[0] !== 32'h1c000040) begin bad++; $display("FAIL compact got=%b/%h exp=01/1c000040", issue_valid, issue_pc[0]); end
    step();
    checks++; if (issue_valid !== 2'b00 || dual_issue_cnt !== exp_cnt) begin bad++; $display("FAIL compact_drain got=%b/%0d exp=00/%0d", issue_valid, dual_issue_cnt, exp_cnt); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_pc [2];
    exp_pc[0] = 32'h108; exp_pc[1] = 32'h110;
    issue_ready = 1'b0;
    set_slot(0, 32'h100, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h104, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    dec_valid = 2'b11; step();
    set_slot(0, 32'h108, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h10c, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_slot(0, 32'h110, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h114, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (dec_ready !== 1'b0 || issue_valid !== 2'b11) begin bad++; $display("FAIL full_state got=%b/%b exp=0/11", dec_ready, issue_valid); end
    step(); step();
    checks++; if (dec_ready !== 1'b0 || issue_pc[0] !== 32'h100 || issue_pc[1] !== 32'h104) begin bad++; $display("FAIL full_hold got=%b/%h/%h exp=0/100/104", dec_ready, issue_pc[0], issue_pc[1]); end
    issue_ready = 1'b1; #1;
    checks++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL full_release got=%b exp=1", dec_ready); end
    step(); dec_valid = 2'b00; #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (issue_valid !== 2'b11 || issue_pc[0] !== exp_pc[k] || issue_pc[1] !== exp_pc[k] + 32'd4) begin bad++; $display("FAIL drain%0d got=%b/%h/%h exp=11/%h", k, issue_valid, issue_pc[0], issue_pc[1], exp_pc[k]); end
      step();
    end
    exp_cnt = exp_cnt + 32'd3;
    checks++; if (issue_valid !== 2'b00 || dual_issue_cnt !== exp_cnt) begin bad++; $display("FAIL drain_end got=%b/%0d exp=00/%0d", issue_valid, dual_issue_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    issue_ready = 1'b0;
    set_slot(0, 32'h200, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h204, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    dec_valid = 2'b11; step();
    set_slot(0, 32'h208, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h20c, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_slot(0, 32'h300, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h304, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    flush = 1'b1; issue_ready = 1'b1; #1;
    checks++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL flush_cycle got=%b exp=00", issue_valid); end
    step(); flush = 1'b0; dec_valid = 2'b00; issue_ready = 1'b0; #1;
    checks++; if (issue_valid !== 2'b00 || dec_ready !== 1'b1 || dual_issue_cnt !== exp_cnt) begin bad++; $display("FAIL flush_after got=%b/%b/%0d exp=00/1/%0d", issue_valid, dec_ready, dual_issue_cnt, exp_cnt); end
    set_slot(0, 32'h400, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h404, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    dec_valid = 2'b11; step(); dec_valid = 2'b00; #1;
    checks++; if (issue_valid !== 2'b11 || issue_pc[0] !== 32'h400 || issue_pc[1] !== 32'h404) begin bad++; $display("FAIL flush_new got=%b/%h/%h exp=11/400/404", issue_valid, issue_pc[0], issue_pc[1]); end
    issue_ready = 1'b1; step(); exp_cnt = exp_cnt + 32'd1;
    checks++; if (issue_valid !== 2'b00 || dual_issue_cnt !== exp_cnt) begin bad++; $display("FAIL flush_drain got=%b/%0d exp=00/%0d", issue_valid, dual_issue_cnt, exp_cnt); end
  endtask

  task automatic test_rst_flush();
    issue_ready = 1'b0;
    set_slot(0, 32'h500, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_slot(1, 32'h504, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    dec_valid = 2'b11; step(); dec_valid = 2'b00;
    rst = 1'b1; flush = 1'b1; issue_ready = 1'b1; step();
    rst = 1'b0; flush = 1'b0; #1;
    checks++; if (dual_issue_cnt !== 32'd0 || issue_valid !== 2'b00 || dec_ready !== 1'b1) begin bad++; $display("FAIL rst_flush got=%0d/%b/%b exp=0/00/1", dual_issue_cnt, issue_valid, dec_ready); end
  endtask

  initial begin
    test_reset();
    test_dual();
    test_raw();
    test_r0();
    test_solo();
    test_waw_compact();
    test_full_wrap();
    test_flush();
    test_rst_flush();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end
endmodule
